// File: rtl/frame_int_timer.sv
// Frame timing generator: position counters, frame strobe, FLASH phase and Z80 INT,
// the latter either a fixed-length pulse or held until acknowledged/timeout.
module frame_int_timer #(
  parameter int LINE_CLKS    = 448,
  parameter int FRAME_LINES  = 312,
  parameter int INT_LINE     = 0,
  parameter int INT_COL      = 0,
  parameter int INT_LEN      = 64,
  parameter int INT_MODE     = 0,
  parameter int FLASH_FRAMES = 16,
  localparam int HW = $clog2(LINE_CLKS),
  localparam int VW = $clog2(FRAME_LINES),
  localparam int LW = $clog2(INT_LEN + 1),
  localparam int FW = $clog2(FLASH_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          irq_en,
  input  logic          m1_n,
  input  logic          iorq_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          frame_start,
  output logic          flash,
  output logic          int_n
);

  logic [LW-1:0] len_cnt;
  logic [FW-1:0] frame_cnt;

  logic          h_last;
  logic          v_last;
  logic [HW-1:0] h_next;
  logic [VW-1:0] v_next;
  logic          to_origin;
  logic          trigger;
  logic          ack;

  always_comb begin
    h_last    = (hcount == HW'(LINE_CLKS - 1));
    v_last    = (vcount == VW'(FRAME_LINES - 1));
    h_next    = h_last ? '0 : hcount + HW'(1);
    v_next    = vcount;
    if (h_last) begin
      v_next = v_last ? '0 : vcount + VW'(1);
    end
    to_origin = en && h_last && v_last;
    // Triggers are defined by the position the counters move to, so they need en.
    trigger   = en && irq_en && (h_next == HW'(INT_COL)) && (v_next == VW'(INT_LINE));
    ack       = (INT_MODE == 1) && !m1_n && !iorq_n && !int_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
      flash       <= 1'b0;
      int_n       <= 1'b1;
      len_cnt     <= '0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= to_origin;
      if (en) begin
        hcount <= h_next;
        vcount <= v_next;
      end

      if (to_origin) begin
        if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
          frame_cnt <= '0;
          flash     <= ~flash;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      // A trigger outranks both timeout and acknowledge on the same edge.
      if (trigger) begin
        int_n   <= 1'b0;
        len_cnt <= LW'(INT_LEN - 1);
      end else if (!int_n) begin
        if (en) begin
          if (len_cnt == '0) begin
            int_n <= 1'b1;
          end else begin
            len_cnt <= len_cnt - LW'(1);
          end
        end
        if (ack) begin
          int_n <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_int_timer.sv
// Bench for frame_int_timer: three instances (pulse/3, held/10, pulse/10) share stimulus
// and are compared every cycle against a model based on the count of enabled cycles.
module tb_frame_int_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  logic irq_en = 1'b0;
  logic m1_n = 1'b1;
  logic iorq_n = 1'b1;

  logic [2:0] hc0, hc1, hc2;
  logic [1:0] vc0, vc1, vc2;
  logic       fs0, fs1, fs2;
  logic       fl0, fl1, fl2;
  logic       in0, in1, in2;

  int checks = 0;
  int fails  = 0;

  // Model state: n = enabled edges since reset; per-instance INT state.
  int n = 0;
  bit fs_m = 1'b0;
  int lens[3]  = '{3, 10, 10};
  int modes[3] = '{0, 1, 0};
  bit lo[3]    = '{1'b0, 1'b0, 1'b0};
  int tr[3]    = '{0, 0, 0};

  always #5 clk = ~clk;

  frame_int_timer #(.LINE_CLKS(8), .FRAME_LINES(4), .INT_LINE(1), .INT_COL(2),
                    .INT_LEN(3), .INT_MODE(0), .FLASH_FRAMES(2)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .irq_en(irq_en), .m1_n(m1_n), .iorq_n(iorq_n),
    .hcount(hc0), .vcount(vc0), .frame_start(fs0), .flash(fl0), .int_n(in0));

  frame_int_timer #(.LINE_CLKS(8), .FRAME_LINES(4), .INT_LINE(1), .INT_COL(2),
                    .INT_LEN(10), .INT_MODE(1), .FLASH_FRAMES(2)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .irq_en(irq_en), .m1_n(m1_n), .iorq_n(iorq_n),
    .hcount(hc1), .vcount(vc1), .frame_start(fs1), .flash(fl1), .int_n(in1));

  frame_int_timer #(.LINE_CLKS(8), .FRAME_LINES(4), .INT_LINE(1), .INT_COL(2),
                    .INT_LEN(10), .INT_MODE(0), .FLASH_FRAMES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .en(en), .irq_en(irq_en), .m1_n(m1_n), .iorq_n(iorq_n),
    .hcount(hc2), .vcount(vc2), .frame_start(fs2), .flash(fl2), .int_n(in2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    fs_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lo[i] = 1'b0;
      tr[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit ack;
    if (!reset_n) begin
      model_reset();
    end else begin
      fs_m = 1'b0;
      if (en) begin
        n++;
        fs_m = (n % 32 == 0);
      end
      for (int i = 0; i < 3; i++) begin
        ack = (modes[i] == 1) && !m1_n && !iorq_n;
        if (en && irq_en && (n % 32 == 10)) begin
          lo[i] = 1'b1;
          tr[i] = n;
        end else if (lo[i]) begin
          if ((en && (n - tr[i] >= lens[i])) || ack) lo[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("hcount", 32'(hc0), 32'(n % 8));
    chk("vcount", 32'(vc0), 32'((n % 32) / 8));
    chk("frame_start", 32'(fs0), 32'(fs_m));
    chk("flash", 32'(fl0), 32'((n / 64) % 2));
    chk("hcount_u1", 32'(hc1), 32'(n % 8));
    chk("int_n_u0", 32'(in0), 32'(!lo[0]));
    chk("int_n_u1", 32'(in1), 32'(!lo[1]));
    chk("int_n_u2", 32'(in2), 32'(!lo[2]));
  endtask

  task automatic check_reset_values();
    chk("rst_hcount", 32'(hc0), 32'd0);
    chk("rst_vcount", 32'(vc0), 32'd0);
    chk("rst_frame_start", 32'(fs0), 32'd0);
    chk("rst_flash", 32'(fl0), 32'd0);
    chk("rst_int_n_u0", 32'(in0), 32'd1);
    chk("rst_int_n_u1", 32'(in1), 32'd1);
    chk("rst_int_n_u2", 32'(in2), 32'd1);
  endtask

  task automatic step(input logic e, input logic ie, input logic m1, input logic io);
    en = e;
    irq_en = ie;
    m1_n = m1;
    iorq_n = io;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    fails++;
    $error("FAIL %s got timeout exp event (n=%0d)", tag, n);
  endtask

  task automatic run_to_trigger(input string tag);
    int k;
    for (k = 0; k < 64 && !(n % 32 == 9); k++) step(1'b1, 1'b1, 1'b1, 1'b1);
    if (k == 64) bound_fail(tag);
    step(1'b1, 1'b1, 1'b1, 1'b1);  // this edge lands on (1,2)
  endtask

  initial begin
    // Power-on reset
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b1;
    model_reset();

    $display("phase: free-run");
    for (int k = 0; k < 140; k++) step(1'b1, 1'b1, 1'b1, 1'b1);

    $display("phase: acknowledge one cycle after trigger");
    run_to_trigger("ack_wait");
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ack_u1_released", 32'(in1), 32'd1);
    chk("ack_u2_ignored", 32'(in2), 32'd0);
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1, 1'b1, 1'b1);

    $display("phase: ack with en low");
    run_to_trigger("ack_en0_wait");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b1, 1'b1);

    $display("phase: gaps");
    for (int k = 0; k < 200; k++) step(1'($urandom % 2), 1'b1, 1'b1, 1'b1);

    $display("phase: masking");
    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 1'b1, 1'b1);
    run_to_trigger("mask_wait");
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 1'b1, 1'b1);

    $display("phase: random");
    for (int k = 0; k < 300; k++)
      step(1'($urandom % 4 != 0), 1'($urandom % 4 != 0), 1'($urandom % 2), 1'($urandom % 2));

    $display("phase: reset mid-interrupt");
    run_to_trigger("rst_wait");
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("pre_rst_int_low", 32'(in0), 32'd0);
    reset_n = 1'b0;
    #1 check_reset_values();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 80; k++) step(1'b1, 1'b1, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule
